psi_rx: RTL and testbench

- Serial-to-parallel receiver at the far end of the psi serial link.
- Hunts for the SOF pattern on s_data and deserializes LSB-first dwords.
- Strips the SOF/EOF framing and presents each payload dword on a parallel output with valid and pkt_end strobes.
- Feeds a downstream FIFO or DMA sink; the serial line has no backpressure, so the block never stalls.

---
 rtl/psi_rx_pkg.sv | 22 ++
 rtl/psi_rx_shift.sv | 33 +++
 rtl/psi_rx.sv | 146 ++++++++++++++
 tb/tb_psi_rx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psi_rx_pkg.sv
// Shared psi link constants and state encodings for the transmitter and the receiver.
package psi_rx_pkg;

   localparam int unsigned PSI_DSIZE = 32;
   localparam logic [31:0] SOF_WORD  = 32'h5a5a5a5a;
   localparam logic [31:0] EOF_WORD  = 32'h0f0f0f0f;
   localparam logic [15:0] EOF_TAIL  = 16'h0f0f;

   typedef enum logic [1:0] {
      TxIdle,
      TxSof,
      TxData,
      TxEof
   } psi_tx_state_e;

   typedef enum logic [1:0] {
      RxHunt,
      RxData,
      RxTail
   } psi_rx_state_e;

endpackage

// File: rtl/psi_rx_shift.sv
// LSB-first serial shift register plus free-running bit counter with load-clear.
module psi_rx_shift
   import psi_rx_pkg::*;
#(
   parameter int unsigned DSIZE = PSI_DSIZE,
   parameter int unsigned CntW  = $clog2(DSIZE)
) (
   input  logic             s_clk,
   input  logic             n_rst,
   input  logic             s_data,
   input  logic             cnt_clr,
   output logic [DSIZE-1:0] next_sr,
   output logic [CntW-1:0]  bit_cnt
);

   logic [DSIZE-1:0] sr_q;

   // Word as it will look after this edge; the FSM decides on it directly.
   always_comb begin
      next_sr = {s_data, sr_q[DSIZE-1:1]};
   end

   always_ff @(posedge s_clk) begin
      if (!n_rst) begin
         sr_q    <= '0;
         bit_cnt <= '0;
      end else begin
         sr_q    <= next_sr;
         bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/psi_rx.sv
// psi serial receiver: SOF hunt, dword deserialization, EOF/tail check, one-word hold for pkt_end.
// Optional statistics counters enabled by defining PSI_RX_STATS_EN.
module psi_rx
   import psi_rx_pkg::*;
#(
   parameter int unsigned DSIZE  = 32,
   parameter int unsigned MAX_DW = 128
) (
   input  logic             s_clk,
   input  logic             n_rst,
   input  logic             s_data,
   output logic [DSIZE-1:0] data,
   output logic             valid,
   output logic             pkt_end,
   output logic             frame_err,
`ifdef PSI_RX_STATS_EN
   output logic [15:0]      pkt_cnt,
   output logic [31:0]      dword_cnt,
`endif
   output logic             busy
);

   localparam int unsigned CntW = $clog2(DSIZE);
   localparam int unsigned DwW  = $clog2(MAX_DW + 1);

   psi_rx_state_e    state_q;
   logic [DSIZE-1:0] hold_q;
   logic             hold_vld_q;
   logic [DwW-1:0]   dw_cnt_q;
   logic             err_pend_q;
   logic [DSIZE-1:0] next_sr;
   logic [CntW-1:0]  bit_cnt;
   logic             cnt_clr;
   logic             word_done;
   logic             tail_done;

   always_comb begin
      word_done = (bit_cnt == CntW'(DSIZE - 1));
      tail_done = (bit_cnt == CntW'(DSIZE / 2 - 1));
      cnt_clr   = ((state_q == RxHunt) && (next_sr == SOF_WORD)) ||
                  ((state_q == RxData) && word_done && (next_sr == EOF_WORD));
   end

   psi_rx_shift #(
      .DSIZE (DSIZE),
      .CntW  (CntW)
   ) u_shift (
      .s_clk   (s_clk),
      .n_rst   (n_rst),
      .s_data  (s_data),
      .cnt_clr (cnt_clr),
      .next_sr (next_sr),
      .bit_cnt (bit_cnt)
   );

   always_ff @(posedge s_clk) begin
      if (!n_rst) begin
         state_q    <= RxHunt;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         dw_cnt_q   <= '0;
         err_pend_q <= 1'b0;
         data       <= '0;
         valid      <= 1'b0;
         pkt_end    <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         valid      <= 1'b0;
         pkt_end    <= 1'b0;
         frame_err  <= err_pend_q;
         err_pend_q <= 1'b0;
         case (state_q)
            RxHunt: begin
               if (next_sr == SOF_WORD) begin
                  dw_cnt_q   <= '0;
                  hold_vld_q <= 1'b0;
                  busy       <= 1'b1;
                  state_q    <= RxData;
               end
            end
            RxData: begin
               if (word_done) begin
                  if (next_sr == EOF_WORD) begin
                     state_q <= RxTail;
                     if (hold_vld_q) begin
                        data       <= hold_q;
                        valid      <= 1'b1;
                        pkt_end    <= 1'b1;
                        hold_vld_q <= 1'b0;
                     end else begin
                        frame_err <= 1'b1;
                     end
                  end else begin
                     if (hold_vld_q) begin
                        data  <= hold_q;
                        valid <= 1'b1;
                     end
                     if (dw_cnt_q == DwW'(MAX_DW)) begin
                        // Last held dword still goes out; the error strobe trails it by a
                        // cycle so valid and frame_err never coincide.
                        hold_vld_q <= 1'b0;
                        busy       <= 1'b0;
                        state_q    <= RxHunt;
                        if (hold_vld_q) begin
                           err_pend_q <= 1'b1;
                        end else begin
                           frame_err <= 1'b1;
                        end
                     end else begin
                        hold_q     <= next_sr;
                        hold_vld_q <= 1'b1;
                        dw_cnt_q   <= dw_cnt_q + 1'b1;
                     end
                  end
               end
            end
            RxTail: begin
               if (tail_done) begin
                  if (next_sr[DSIZE-1:DSIZE/2] != EOF_TAIL) begin
                     frame_err <= 1'b1;
                  end
                  busy    <= 1'b0;
                  state_q <= RxHunt;
               end
            end
            default: state_q <= RxHunt;
         endcase
      end
   end

`ifdef PSI_RX_STATS_EN
   always_ff @(posedge s_clk) begin
      if (!n_rst) begin
         pkt_cnt   <= '0;
         dword_cnt <= '0;
      end else if (valid) begin
         dword_cnt <= dword_cnt + 1'b1;
         if (pkt_end) begin
            pkt_cnt <= pkt_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_psi_rx.sv
// Directed self-checking bench for psi_rx; also checks statistics when PSI_RX_STATS_EN is defined.
module tb_psi_rx;

   logic        s_clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        s_data = 1'b0;
   logic [31:0] data;
   logic        valid;
   logic        pkt_end;
   logic        frame_err;
   logic        busy;
`ifdef PSI_RX_STATS_EN
   logic [15:0] pkt_cnt;
   logic [31:0] dword_cnt;
`endif

   int vectors = 0;
   int errors  = 0;

   logic [31:0] cap_data[$];
   logic        cap_end[$];
   int          err_cnt  = 0;
   int          both_cnt = 0;

   psi_rx #(
      .DSIZE  (32),
      .MAX_DW (128)
   ) dut (
      .s_clk     (s_clk),
      .n_rst     (n_rst),
      .s_data    (s_data),
      .data      (data),
      .valid     (valid),
      .pkt_end   (pkt_end),
      .frame_err (frame_err),
`ifdef PSI_RX_STATS_EN
      .pkt_cnt   (pkt_cnt),
      .dword_cnt (dword_cnt),
`endif
      .busy      (busy)
   );

   always #5 s_clk = ~s_clk;

   // Mid-cycle monitor: each registered pulse is seen exactly once.
   always @(negedge s_clk) begin
      if (valid === 1'b1) begin
         cap_data.push_back(data);
         cap_end.push_back(pkt_end);
      end
      if (frame_err === 1'b1) err_cnt++;
      if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
   end

   task automatic send_bit(input logic b);
      s_data = b;
      @(posedge s_clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 32; i++) send_bit(w[i]);
   endtask

   task automatic send_tail(input logic [15:0] t);
      for (int i = 0; i < 16; i++) send_bit(t[i]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b0);
   endtask

   task automatic clear_capture();
      cap_data.delete();
      cap_end.delete();
      err_cnt  = 0;
      both_cnt = 0;
   endtask

   task automatic test_reset();
      n_rst = 1'b0;
      idle(3);
      vectors++;
      if ({valid, pkt_end, frame_err, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_strobes got %b want 0000", {valid, pkt_end, frame_err, busy});
      end
      vectors++;
      if (data !== 32'h0) begin
         errors++;
         $display("FAIL reset_data got %h want 00000000", data);
      end
`ifdef PSI_RX_STATS_EN
      vectors++;
      if (pkt_cnt !== 16'h0 || dword_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_stats got %0d/%0d want 0/0", pkt_cnt, dword_cnt);
      end
`endif
      n_rst = 1'b1;
      idle(2);
   endtask

   task automatic test_single();
      clear_capture();
      idle(40);
      send_word(32'h5a5a5a5a);
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_sof got %b want 1", busy);
      end
      send_word(32'h12345678);
      vectors++;
      if (valid !== 1'b0) begin
         errors++;
         $display("FAIL single_first_word_held got valid=%b want 0", valid);
      end
      send_word(32'h9abcdef0);
      vectors++;
      if (valid !== 1'b1 || data !== 32'h12345678 || pkt_end !== 1'b0) begin
         errors++;
         $display("FAIL single_latency got v=%b d=%h e=%b want v=1 d=12345678 e=0",
                  valid, data, pkt_end);
      end
      send_word(32'h0f0f0f0f);
      vectors++;
      if (valid !== 1'b1 || data !== 32'h9abcdef0 || pkt_end !== 1'b1) begin
         errors++;
         $display("FAIL single_last got v=%b d=%h e=%b want v=1 d=9abcdef0 e=1",
                  valid, data, pkt_end);
      end
      for (int i = 0; i < 15; i++) send_bit(1'(16'h0f0f >> i));
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL single_busy_tail got %b want 1", busy);
      end
      send_bit(1'b0);
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_fall got %b want 0", busy);
      end
      idle(4);
      vectors++;
      if (data !== 32'h9abcdef0) begin
         errors++;
         $display("FAIL single_data_hold got %h want 9abcdef0", data);
      end
      vectors++;
      if (cap_data.size() !== 2 || err_cnt !== 0) begin
         errors++;
         $display("FAIL single_counts got valid=%0d err=%0d want 2/0", cap_data.size(), err_cnt);
      end
   endtask

   task automatic test_unaligned();
      logic [2:0] r;
      clear_capture();
      r = 3'($urandom);
      for (int i = 0; i < 3; i++) send_bit(r[i]);
      send_word(32'h5a5a5a5a);
      send_word(32'hdeadbeef);
      send_word(32'h0f0f0f0f);
      send_tail(16'h0f0f);
      idle(4);
      vectors++;
      if (cap_data.size() !== 1) begin
         errors++;
         $display("FAIL unaligned_count got %0d want 1", cap_data.size());
      end else begin
         vectors++;
         if (cap_data[0] !== 32'hdeadbeef || cap_end[0] !== 1'b1) begin
            errors++;
            $display("FAIL unaligned_word got %h/%b want deadbeef/1", cap_data[0], cap_end[0]);
         end
      end
   endtask

   task automatic test_empty();
      clear_capture();
      send_word(32'h5a5a5a5a);
      send_word(32'h0f0f0f0f);
      send_tail(16'h0f0f);
      idle(4);
      vectors++;
      if (err_cnt !== 1 || cap_data.size() !== 0) begin
         errors++;
         $display("FAIL empty_pkt got err=%0d valid=%0d want 1/0", err_cnt, cap_data.size());
      end
   endtask

   task automatic test_bad_tail();
      clear_capture();
      send_word(32'h5a5a5a5a);
      send_word(32'h11223344);
      send_word(32'h0f0f0f0f);
      send_tail(16'h0f0e);
      vectors++;
      if (frame_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bad_tail_strobe got err=%b busy=%b want 1/0", frame_err, busy);
      end
      idle(4);
      vectors++;
      if (cap_data.size() !== 1 || err_cnt !== 1) begin
         errors++;
         $display("FAIL bad_tail_counts got valid=%0d err=%0d want 1/1", cap_data.size(), err_cnt);
      end else begin
         vectors++;
         if (cap_data[0] !== 32'h11223344 || cap_end[0] !== 1'b1) begin
            errors++;
            $display("FAIL bad_tail_word got %h/%b want 11223344/1", cap_data[0], cap_end[0]);
         end
      end
   endtask

   task automatic test_oversize();
      int ends;
      clear_capture();
      send_word(32'h5a5a5a5a);
      for (int i = 0; i < 129; i++) send_word(32'h10000000 + 32'(i));
      idle(4);
      ends = 0;
      foreach (cap_end[i]) if (cap_end[i] === 1'b1) ends++;
      vectors++;
      if (cap_data.size() !== 128 || ends !== 0) begin
         errors++;
         $display("FAIL oversize_valid got %0d valid, %0d end want 128/0", cap_data.size(), ends);
      end else begin
         vectors++;
         if (cap_data[127] !== 32'h1000007f) begin
            errors++;
            $display("FAIL oversize_last got %h want 1000007f", cap_data[127]);
         end
      end
      vectors++;
      if (err_cnt !== 1 || both_cnt !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL oversize_err got err=%0d both=%0d busy=%b want 1/0/0",
                  err_cnt, both_cnt, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w[4];
      int ends;
`ifdef PSI_RX_STATS_EN
      logic [15:0] p0;
      logic [31:0] d0;
      p0 = pkt_cnt;
      d0 = dword_cnt;
`endif
      exp_w = '{32'hcafe0001, 32'hcafe0002, 32'h00c0ffee, 32'h80000001};
      clear_capture();
      for (int p = 0; p < 2; p++) begin
         send_word(32'h5a5a5a5a);
         send_word(exp_w[2*p]);
         send_word(exp_w[2*p+1]);
         send_word(32'h0f0f0f0f);
         send_tail(16'h0f0f);
      end
      idle(4);
      ends = 0;
      foreach (cap_end[i]) if (cap_end[i] === 1'b1) ends++;
      vectors++;
      if (cap_data.size() !== 4 || ends !== 2 || err_cnt !== 0) begin
         errors++;
         $display("FAIL b2b_counts got valid=%0d end=%0d err=%0d want 4/2/0",
                  cap_data.size(), ends, err_cnt);
      end else begin
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap_data[i] !== exp_w[i] || cap_end[i] !== 1'(i % 2)) begin
               errors++;
               $display("FAIL b2b_word%0d got %h/%b want %h/%b", i, cap_data[i], cap_end[i],
                        exp_w[i], 1'(i % 2));
            end
         end
      end
`ifdef PSI_RX_STATS_EN
      vectors++;
      if (pkt_cnt !== p0 + 16'd2 || dword_cnt !== d0 + 32'd4) begin
         errors++;
         $display("FAIL b2b_stats got pkt+%0d dw+%0d want +2/+4", pkt_cnt - p0, dword_cnt - d0);
      end
`endif
   endtask

   task automatic test_reset_mid();
      clear_capture();
      send_word(32'h5a5a5a5a);
      send_word(32'h01020304);
      for (int i = 0; i < 10; i++) send_bit(1'(32'h05060708 >> i));
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_busy_before got %b want 1", busy);
      end
      n_rst = 1'b0;
      send_bit(1'b1);
      vectors++;
      if ({valid, pkt_end, frame_err, busy} !== 4'b0000 || data !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid_clear got %b data=%h want 0000 data=0",
                  {valid, pkt_end, frame_err, busy}, data);
      end
`ifdef PSI_RX_STATS_EN
      vectors++;
      if (pkt_cnt !== 16'h0) begin
         errors++;
         $display("FAIL rst_mid_pkt_cnt got %0d want 0", pkt_cnt);
      end
`endif
      n_rst = 1'b1;
      idle(40);
      vectors++;
      if (err_cnt !== 0 || cap_data.size() !== 0) begin
         errors++;
         $display("FAIL rst_mid_silent got err=%0d valid=%0d want 0/0", err_cnt, cap_data.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_unaligned();
      test_empty();
      test_bad_tail();
      test_oversize();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
